mc_ctrl_fsm: RTL

Multi-cycle control unit that sequences the shared ALU, register file, memory and PC through IF/ID/EXE/MEM/WB.
- Decodes the IR-held OpCode/func.
- Drives ALUSrc/ALUop for the ALU.
- Consumes the ALU's zero, condition and overflow flags.
- Counts retired instructions.
- Sits between the IR and every datapath write enable / mux select.

---
 rtl/mc_ctrl_pkg.sv | 77 +++++++
 rtl/mc_ctrl_fsm_decode.sv | 63 ++++++
 rtl/mc_ctrl_fsm.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state codes, MIPS opcode/func
// constants, datapath select encodings and the decoded-instruction record.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type func codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // PCSrc
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  // RegDst
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // MemtoReg
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // ALUop
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  typedef enum logic [3:0] {
    C_ILLEGAL = 4'd0,
    C_J       = 4'd1,
    C_JAL     = 4'd2,
    C_JR      = 4'd3,
    C_RALU    = 4'd4,
    C_IALU    = 4'd5,
    C_LOAD    = 4'd6,
    C_STORE   = 4'd7,
    C_BEQ     = 4'd8,
    C_BGTZ    = 4'd9
  } instr_class_t;

  typedef struct packed {
    instr_class_t cls;
    logic         alu_src;
    logic [1:0]   alu_op;
    logic         is_rtype;
  } dec_t;

  function automatic logic is_branch(input instr_class_t c);
    return (c == C_BEQ) || (c == C_BGTZ);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational OpCode/func decoder: instruction class, legality and the ALU
// operand/operation selects used from EXE onward.
module mc_ctrl_fsm_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_func,
  output dec_t       o_dec
);

  always_comb begin
    o_dec          = '0;
    o_dec.cls      = C_ILLEGAL;
    o_dec.alu_src  = 1'b0;
    o_dec.alu_op   = ALU_ADD;
    o_dec.is_rtype = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.is_rtype = 1'b1;
        case (i_func)
          FN_ADDU: begin
            o_dec.cls    = C_RALU;
            o_dec.alu_op = ALU_ADD;
          end
          FN_SUBU, FN_SLT: begin
            o_dec.cls    = C_RALU;
            o_dec.alu_op = ALU_SUB;
          end
          FN_JR:   o_dec.cls = C_JR;
          default: o_dec.cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LUI: begin
        o_dec.cls     = C_IALU;
        o_dec.alu_src = 1'b1;
        o_dec.alu_op  = ALU_ADD;
      end
      OP_ORI: begin
        o_dec.cls     = C_IALU;
        o_dec.alu_src = 1'b1;
        o_dec.alu_op  = ALU_OR;
      end
      OP_LW: begin
        o_dec.cls     = C_LOAD;
        o_dec.alu_src = 1'b1;
      end
      OP_SW: begin
        o_dec.cls     = C_STORE;
        o_dec.alu_src = 1'b1;
      end
      OP_BEQ: begin
        o_dec.cls    = C_BEQ;
        o_dec.alu_op = ALU_SUB;
      end
      // bgtz relies on the ALU condition flag, so a plain add is enough
      OP_BGTZ: o_dec.cls = C_BGTZ;
      OP_J:    o_dec.cls = C_J;
      OP_JAL:  o_dec.cls = C_JAL;
      default: o_dec.cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EXE/MEM/WB controller with a retired-instruction counter.
// Define OVERFLOW_TRAP_EN to suppress the addi write-back on overflow and add ovf_trap.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] ADDI_OP = 6'b001000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             condition,
  input  logic             overflow,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUop,
  output logic [2:0]       state,
  output logic             illegal,
`ifdef OVERFLOW_TRAP_EN
  output logic             ovf_trap,
`endif
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic             w_retire;
  logic             w_trap;
  dec_t             w_dec;

  mc_ctrl_fsm_decode u_decode (
    .i_opcode (OpCode),
    .i_func   (func),
    .o_dec    (w_dec)
  );

`ifdef OVERFLOW_TRAP_EN
  assign w_trap   = (OpCode == ADDI_OP) && overflow;
  assign ovf_trap = (r_state == S_WB) && w_trap && !rst;
`else
  logic w_unused_ovf;
  assign w_trap       = 1'b0;
  assign w_unused_ovf = overflow ^ (OpCode == ADDI_OP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state = S_IF;
    w_retire     = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = PC_PLUS4;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = RD_RT;
    MemtoReg     = WB_ALU;
    MemWrite     = 1'b0;
    ALUSrc       = 1'b0;
    ALUop        = ALU_ADD;
    illegal      = 1'b0;
    case (r_state)
      S_IF: begin
        IRWrite      = 1'b1;
        PCWrite      = 1'b1;
        PCSrc        = PC_PLUS4;
        w_next_state = S_ID;
      end
      S_ID: begin
        case (w_dec.cls)
          C_J: begin
            PCWrite  = 1'b1;
            PCSrc    = PC_JUMP;
            w_retire = 1'b1;
          end
          C_JAL: begin
            PCWrite  = 1'b1;
            PCSrc    = PC_JUMP;
            RegWrite = 1'b1;
            RegDst   = RD_RA;
            MemtoReg = WB_PC4;
            w_retire = 1'b1;
          end
          C_JR: begin
            PCWrite  = 1'b1;
            PCSrc    = PC_RS;
            w_retire = 1'b1;
          end
          C_ILLEGAL: illegal = 1'b1;
          default:   w_next_state = S_EXE;
        endcase
      end
      S_EXE: begin
        ALUSrc = w_dec.alu_src;
        ALUop  = w_dec.alu_op;
        if (is_branch(w_dec.cls)) begin
          if ((w_dec.cls == C_BEQ && zero) || (w_dec.cls == C_BGTZ && condition)) begin
            PCWrite = 1'b1;
            PCSrc   = PC_BRANCH;
          end
          w_retire = 1'b1;
        end else if (w_dec.cls == C_LOAD || w_dec.cls == C_STORE) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        ALUSrc = w_dec.alu_src;
        ALUop  = w_dec.alu_op;
        if (w_dec.cls == C_STORE) begin
          MemWrite = 1'b1;
          w_retire = 1'b1;
        end else if (w_dec.cls == C_LOAD) begin
          w_next_state = S_WB;
        end
      end
      S_WB: begin
        ALUSrc   = w_dec.alu_src;
        ALUop    = w_dec.alu_op;
        RegWrite = !w_trap;
        RegDst   = w_dec.is_rtype ? RD_RD : RD_RT;
        MemtoReg = (w_dec.cls == C_LOAD) ? WB_MEM : WB_ALU;
        w_retire = 1'b1;
      end
      default: w_next_state = S_IF;
    endcase
    // Reset wins over every write enable so an abandoned instruction leaves no trace
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state       = r_state;
  assign instr_count = r_count;

endmodule
